gb_rom_loader: RTL and testbench
================================

# gb_rom_loader

Receives cartridge ROM images from the HPS download channel and writes them into the shared cartridge ROM dual-port RAM ahead of both cart interfaces. It throttles the HPS with `ioctl_wait` so each 16-bit word is written exactly once in a CPU write slot. While the image streams in, it captures the header fields the cart mappers need and verifies the header checksum. It raises `cart_ready` once a complete image is present.

## Interface
Parameters:
- `AW`, 24: word address width of ROM RAM; byte address width is `AW+1`.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: write-slot strobe, one `clk_sys` cycle wide (`ce_cpu2x` or `ce_cpu` per speed).
- `ioctl_download` in 1: download active.
- `ioctl_index` in 8: file type; accepted values are 0x01, 0x41 and 0x80.
- `ioctl_wr` in 1: one-cycle word strobe.
- `ioctl_addr` in AW+1: byte address, always even.
- `ioctl_dout` in 16: data word; low byte is the even address.
- `ioctl_wait` out 1: throttle to the HPS.
- `rom_we` out 1: ROM RAM write enable.
- `rom_addr` out AW: word address, equal to `ioctl_addr[AW:1]`.
- `rom_data` out 16: word to write.
- `cart_download` out 1: `ioctl_download` AND an accepted index.
- `cart_ready` out 1: a complete image is loaded.
- `cart_cgb_flag`, `cart_mbc_type`, `cart_rom_size`, `cart_ram_size` out 8 each: header bytes 0x143, 0x147, 0x148 and 0x149.
- `hdr_ok` out 1: header checksum matched.
- `rom_words` out AW: highest written word address + 1.

## Operation
FSM states are IDLE, PEND and WRITE.
- **IDLE**
  - On `ioctl_wr & cart_download`: latch address and data, set `ioctl_wait`, go to PEND.
  - `ioctl_wr` without `cart_download` is ignored and `ioctl_wait` stays 0.
- **PEND**
  - On `ce`: go to WRITE.
  - `ioctl_wr` arriving in PEND or WRITE is a protocol violation and is ignored.
- **WRITE**
  - `rom_we`=1 for exactly this one cycle.
  - Clear `ioctl_wait`, go to IDLE.
  - Update `rom_words` = max(`rom_words`, addr+1).
- **Header capture**, applied at the WRITE cycle:
  - Word 0x142: `cart_cgb_flag` ← high byte.
  - Word 0x146: `cart_mbc_type` ← high byte.
  - Word 0x148: `cart_rom_size` ← low byte, `cart_ram_size` ← high byte.
- **Checksum**
  - 8-bit accumulator `x`, cleared at download start.
  - For each byte b at 0x134..0x14C: `x = x - b - 1`, modulo 256.
  - At word 0x14C, the low byte is accumulated first; then `hdr_ok` ← (`x` == high byte).
  - Words outside 0x134..0x14C do not touch `x`.
- **Download start** (rising edge of `cart_download`): clear `cart_ready`, `hdr_ok`, `rom_words` and `x`. Header registers keep their old values until overwritten.
- **Download end** (falling edge of `cart_download`):
  - `cart_ready` ← (`rom_words` != 0).
  - If a write is still in PEND or WRITE, it completes normally. `cart_ready` is then evaluated in the cycle after its WRITE.
- **Reset at any time:**
  - All outputs are 0, including header registers and `rom_words`.
  - State returns to IDLE and any pending word is discarded.

## Timing
- `ioctl_wr` at cycle N → `ioctl_wait`=1 from N+1.
- First `ce` sampled in PEND at cycle M (M ≥ N+1) → `rom_we`=1 in cycle M+1 only; `ioctl_wait`=0 from M+2.
- `rom_addr` and `rom_data` are stable from N+1 through M+1.
- Worst-case latency is N+1 plus one `ce` period plus 1 cycle.
- All outputs are registered. `cart_download` is the only combinational output.
- Header and `hdr_ok` updates are visible the cycle after WRITE.
- `cart_ready` rises 1 cycle after the end-of-download edge, or 1 cycle after the trailing WRITE.
- `ce` coincident with `ioctl_wr` in IDLE does not count; the next `ce` is used.

## Test plan
- **Single word:** index 0x01, addr 0x0010, data 0xBEEF, `ce` every 8 cycles.
  - `ioctl_wait` is high from N+1.
  - `rom_we` pulses once with `rom_addr`=0x000008, `rom_data`=0xBEEF.
  - `ioctl_wait` drops 1 cycle later.
- **Full header:** stream 0x000..0x14F of a valid header with bytes 0x143=0x80, 0x147=0x13, 0x148=0x05, 0x149=0x03, then drop `ioctl_download`.
  - Required: `cart_cgb_flag`=0x80, `cart_mbc_type`=0x13, `cart_rom_size`=0x05, `cart_ram_size`=0x03.
  - Required: `hdr_ok`=1, `rom_words`=0xA8, `cart_ready`=1.
- **Bad checksum:** same image with byte 0x14D corrupted → `hdr_ok`=0, `cart_ready`=1.
- **Ignored inputs:**
  - Index 0x05 download: `ioctl_wait` stays 0, `rom_we` never asserts, `cart_ready` unchanged.
  - Second `ioctl_wr` during PEND: exactly one `rom_we` with the first word's data.
- **End with write pending:** drop `ioctl_download` while in PEND.
  - The write completes on the next `ce`.
  - `cart_ready`=1 in the cycle after `rom_we`.
- **Reset mid-operation:** reset in PEND.
  - Next cycle: `ioctl_wait`=0, `rom_we` never asserts, `cart_ready`=0, all header outputs 0x00.
  - A new download after reset restarts cleanly.

Source files
------------

// File: rtl/gb_rom_loader.sv
// Streams HPS cartridge ROM images into the cart ROM RAM one word per CPU write slot,
// capturing the mapper header fields and checking the header checksum on the fly.
module gb_rom_loader #(
  parameter int unsigned AW = 24
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW:0]   ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  output logic          ioctl_wait,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [15:0]   rom_data,
  output logic          cart_download,
  output logic          cart_ready,
  output logic [7:0]    cart_cgb_flag,
  output logic [7:0]    cart_mbc_type,
  output logic [7:0]    cart_rom_size,
  output logic [7:0]    cart_ram_size,
  output logic          hdr_ok,
  output logic [AW-1:0] rom_words
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WRITE} state_t;

  // Word addresses (byte address >> 1) of the header fields
  localparam logic [AW-1:0] W_CGB     = AW'(32'h142 >> 1);
  localparam logic [AW-1:0] W_MBC     = AW'(32'h146 >> 1);
  localparam logic [AW-1:0] W_SIZES   = AW'(32'h148 >> 1);
  localparam logic [AW-1:0] W_CKS_LO  = AW'(32'h134 >> 1);
  localparam logic [AW-1:0] W_CKS_END = AW'(32'h14C >> 1);

  state_t        state_q, state_d;
  logic          wait_q, wait_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          dl_q;
  logic          end_pend_q;
  logic          ready_q;
  logic          hdr_ok_q;
  logic [7:0]    cgb_q, mbc_q, romsz_q, ramsz_q;
  logic [AW-1:0] words_q;
  logic [7:0]    x_q;

  logic          dl_rise, dl_fall, end_now;
  logic [AW-1:0] addr_inc;
  logic [7:0]    x_lo, x_full;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ioctl_addr[0];

  assign cart_download = ioctl_download &
                         ((ioctl_index == 8'h01) | (ioctl_index == 8'h41) | (ioctl_index == 8'h80));

  assign dl_rise  = cart_download & ~dl_q;
  assign dl_fall  = ~cart_download & dl_q;
  assign end_now  = dl_fall | end_pend_q;
  assign addr_inc = addr_q + 1'b1;
  assign x_lo     = x_q - data_q[7:0] - 8'd1;
  assign x_full   = x_lo - data_q[15:8] - 8'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ioctl_wr && cart_download) state_d = S_PEND;
      S_PEND:  if (ce) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_comb begin
    wait_d = (state_d != S_IDLE);
    we_d   = (state_d == S_WRITE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      dl_q       <= 1'b0;
      end_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      hdr_ok_q   <= 1'b0;
      cgb_q      <= '0;
      mbc_q      <= '0;
      romsz_q    <= '0;
      ramsz_q    <= '0;
      words_q    <= '0;
      x_q        <= '0;
    end else begin
      dl_q <= cart_download;
      if (state_q == S_IDLE && state_d == S_PEND) begin
        addr_q <= ioctl_addr[AW:1];
        data_q <= ioctl_dout;
      end
      if (state_q == S_WRITE) begin
        if (addr_inc > words_q) words_q <= addr_inc;
        if (addr_q == W_CGB) cgb_q <= data_q[15:8];
        if (addr_q == W_MBC) mbc_q <= data_q[15:8];
        if (addr_q == W_SIZES) begin
          romsz_q <= data_q[7:0];
          ramsz_q <= data_q[15:8];
        end
        if (addr_q == W_CKS_END) begin
          x_q      <= x_lo;
          hdr_ok_q <= (x_lo == data_q[15:8]);
        end else if (addr_q >= W_CKS_LO && addr_q < W_CKS_END) begin
          x_q <= x_full;
        end
      end
      // A download ending with a word in flight is resolved on that word's WRITE cycle
      if (end_now) begin
        case (state_q)
          S_WRITE: begin
            ready_q    <= 1'b1;
            end_pend_q <= 1'b0;
          end
          S_PEND:  end_pend_q <= 1'b1;
          default: begin
            ready_q    <= (words_q != '0);
            end_pend_q <= 1'b0;
          end
        endcase
      end
      if (dl_rise) begin
        ready_q    <= 1'b0;
        hdr_ok_q   <= 1'b0;
        words_q    <= '0;
        x_q        <= '0;
        end_pend_q <= 1'b0;
      end
    end
  end

  assign ioctl_wait    = wait_q;
  assign rom_we        = we_q;
  assign rom_addr      = addr_q;
  assign rom_data      = data_q;
  assign cart_ready    = ready_q;
  assign hdr_ok        = hdr_ok_q;
  assign cart_cgb_flag = cgb_q;
  assign cart_mbc_type = mbc_q;
  assign cart_rom_size = romsz_q;
  assign cart_ram_size = ramsz_q;
  assign rom_words     = words_q;

endmodule

// File: tb/tb_gb_rom_loader.sv
// Directed bench for gb_rom_loader: single word timing, full header capture/checksum,
// ignored inputs, end-of-download with a pending word, and reset mid-write.
module tb_gb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait, rom_we, cart_download, cart_ready, hdr_ok;
  logic [23:0] rom_addr, rom_words;
  logic [15:0] rom_data;
  logic [7:0]  cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int ce_cnt = 0;
  bit ce_en = 1'b1;
  logic [7:0] img [0:335];

  gb_rom_loader #(.AW(24)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .cart_download(cart_download), .cart_ready(cart_ready),
    .cart_cgb_flag(cart_cgb_flag), .cart_mbc_type(cart_mbc_type),
    .cart_rom_size(cart_rom_size), .cart_ram_size(cart_ram_size),
    .hdr_ok(hdr_ok), .rom_words(rom_words)
  );

  always #5 clk_sys = ~clk_sys;

  // ce: one cycle in eight, driven just after the rising edge
  initial forever begin
    @(posedge clk_sys); #1;
    ce = ce_en && (ce_cnt % 8 == 7);
    ce_cnt++;
  end

  always @(negedge clk_sys) if (rom_we) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic wait_we(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      tick();
      if (rom_we) break;
    end
    if (i == 40) check({tag, "_we_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
    int i;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    for (i = 0; i < 40; i++) begin
      if (!ioctl_wait) break;
      tick();
    end
    if (i == 40) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic stream_image();
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 168; i++)
      wr_word(25'(2 * i), {img[2*i+1], img[2*i]});
    ioctl_download = 1'b0;
    tick(2);
  endtask

  initial begin
    int base;
    logic [7:0] x;

    for (int i = 0; i < 336; i++) img[i] = 8'(i * 7 + 3);
    img[12'h143] = 8'h80;
    img[12'h147] = 8'h13;
    img[12'h148] = 8'h05;
    img[12'h149] = 8'h03;
    x = 8'h00;
    for (int i = 12'h134; i <= 12'h14C; i++) x = x - img[i] - 8'd1;
    img[12'h14D] = x;

    tick(3);
    check("rst_wait", ioctl_wait, 0);
    check("rst_we", rom_we, 0);
    check("rst_ready", cart_ready, 0);
    check("rst_words", rom_words, 0);
    reset = 1'b0;
    tick();

    // Single word
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    tick();
    check("cart_download", cart_download, 1);
    ioctl_addr = 25'h0010;
    ioctl_dout = 16'hBEEF;
    ioctl_wr   = 1'b1;
    base = we_cnt;
    tick();
    ioctl_wr = 1'b0;
    check("sw_wait_n1", ioctl_wait, 1);
    wait_we("sw");
    check("sw_addr", rom_addr, 32'h8);
    check("sw_data", rom_data, 32'hBEEF);
    check("sw_wait_at_we", ioctl_wait, 1);
    tick();
    check("sw_wait_drop", ioctl_wait, 0);
    check("sw_we_once", we_cnt - base, 1);
    ioctl_download = 1'b0;
    tick(2);
    check("sw_ready", cart_ready, 1);
    check("sw_words", rom_words, 32'h9);

    // Full header, valid checksum
    stream_image();
    check("hdr_cgb", cart_cgb_flag, 32'h80);
    check("hdr_mbc", cart_mbc_type, 32'h13);
    check("hdr_romsz", cart_rom_size, 32'h05);
    check("hdr_ramsz", cart_ram_size, 32'h03);
    check("hdr_ok", hdr_ok, 1);
    check("hdr_words", rom_words, 32'hA8);
    check("hdr_ready", cart_ready, 1);

    // Bad checksum
    img[12'h14D] = img[12'h14D] ^ 8'h01;
    stream_image();
    check("bad_hdr_ok", hdr_ok, 0);
    check("bad_ready", cart_ready, 1);

    // Ignored index
    ioctl_index    = 8'h05;
    ioctl_download = 1'b1;
    base = we_cnt;
    tick();
    check("ign_cdl", cart_download, 0);
    ioctl_addr = 25'h0020;
    ioctl_dout = 16'h1234;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("ign_wait", ioctl_wait, 0);
    tick(20);
    ioctl_download = 1'b0;
    tick(2);
    check("ign_we", we_cnt - base, 0);
    check("ign_ready", cart_ready, 1);

    // Second ioctl_wr while PEND
    ce_en = 1'b0;
    ioctl_index    = 8'h41;
    ioctl_download = 1'b1;
    tick(2);
    base = we_cnt;
    ioctl_addr = 25'h0020;
    ioctl_dout = 16'h1111;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_addr = 25'h0022;
    ioctl_dout = 16'h2222;
    tick();
    ioctl_wr = 1'b0;
    check("dup_wait", ioctl_wait, 1);
    ce_en = 1'b1;
    wait_we("dup");
    check("dup_addr", rom_addr, 32'h10);
    check("dup_data", rom_data, 32'h1111);
    tick(20);
    check("dup_we_once", we_cnt - base, 1);

    // End of download while PEND
    ce_en = 1'b0;
    tick();
    ioctl_addr = 25'h0030;
    ioctl_dout = 16'h3333;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick(3);
    check("endp_ready_pend", cart_ready, 0);
    check("endp_wait", ioctl_wait, 1);
    ce_en = 1'b1;
    wait_we("endp");
    check("endp_addr", rom_addr, 32'h18);
    check("endp_ready_at_we", cart_ready, 0);
    tick();
    check("endp_ready", cart_ready, 1);
    check("endp_words", rom_words, 32'h19);

    // Reset while PEND, then a clean download
    ce_en = 1'b0;
    ioctl_index    = 8'h80;
    ioctl_download = 1'b1;
    tick(2);
    ioctl_addr = 25'h0040;
    ioctl_dout = 16'h4444;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("rp_wait_pend", ioctl_wait, 1);
    reset = 1'b1;
    base  = we_cnt;
    tick();
    reset = 1'b0;
    check("rp_wait", ioctl_wait, 0);
    check("rp_ready", cart_ready, 0);
    check("rp_cgb", cart_cgb_flag, 0);
    check("rp_mbc", cart_mbc_type, 0);
    check("rp_romsz", cart_rom_size, 0);
    check("rp_ramsz", cart_ram_size, 0);
    check("rp_words", rom_words, 0);
    ce_en = 1'b1;
    tick(20);
    check("rp_no_we", we_cnt - base, 0);
    wr_word(25'h0050, 16'h5555);
    check("rp_new_addr", rom_addr, 32'h28);
    check("rp_new_data", rom_data, 32'h5555);
    ioctl_download = 1'b0;
    tick(2);
    check("rp_new_ready", cart_ready, 1);
    check("rp_new_words", rom_words, 32'h29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
